// File: rtl/rst_seq.sv
// Staged reset sequencer: releases memory, core and I/O resets in order once DCM lock is
// stable and SDRAM init is done; pulses the DCM reset on timeouts and latches a fault.
module rst_seq #(
   parameter int unsigned LOCK_STABLE = 16,
   parameter int unsigned STAGE_DLY   = 8,
   parameter int unsigned LOCK_TMO    = 4096,
   parameter int unsigned MEM_TMO     = 1024,
   parameter int unsigned DCM_RST_LEN = 4,
   parameter int unsigned MAX_RETRY   = 3,
   parameter int unsigned CW          = 16
) (
   input  logic       clk,
   input  logic       async_n,
   input  logic       dcm_lock,
   input  logic       mem_ready,
   output logic       rst_mem_n,
   output logic       rst_core_n,
   output logic       rst_io_n,
   output logic       dcm_rst,
   output logic       seq_done,
   output logic       fault,
   output logic [7:0] lost_cnt
);

   localparam int unsigned RW = ($clog2(MAX_RETRY + 1) > 2) ? $clog2(MAX_RETRY + 1) : 2;

   localparam logic [CW-1:0] LockStableM1 = CW'(LOCK_STABLE - 1);
   localparam logic [CW-1:0] StageDlyM1   = CW'(STAGE_DLY - 1);
   localparam logic [CW-1:0] LockTmoM1    = CW'(LOCK_TMO - 1);
   localparam logic [CW-1:0] MemTmoM1     = CW'(MEM_TMO - 1);
   localparam logic [CW-1:0] DcmLenM1     = CW'(DCM_RST_LEN - 1);
   localparam logic [RW-1:0] MaxRetry     = RW'(MAX_RETRY);

   typedef enum logic [2:0] {
      StWaitLock,
      StRelMem,
      StCoreDly,
      StIoDly,
      StRun,
      StDcmRst,
      StFault
   } state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [CW-1:0]   tmo_q, tmo_d;
   logic [RW-1:0]   retry_q, retry_d;
   logic [7:0]      lost_q, lost_d;
   logic            lock_s1, lock_s;
   logic            mem_d, core_d, io_d, dcm_d, done_d, fault_d;

   // dcm_lock is asynchronous to clk; only lock_s is used downstream.
   always_ff @(posedge clk or negedge async_n) begin
      if (!async_n) begin
         lock_s1 <= 1'b0;
         lock_s  <= 1'b0;
      end else begin
         lock_s1 <= dcm_lock;
         lock_s  <= lock_s1;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tmo_d   = tmo_q;
      retry_d = retry_q;
      lost_d  = lost_q;
      unique case (state_q)
         StWaitLock: begin
            tmo_d = tmo_q + CW'(1);
            cnt_d = lock_s ? cnt_q + CW'(1) : '0;
            if (lock_s && (cnt_q == LockStableM1)) begin
               state_d = StRelMem;
            end else if (tmo_q == LockTmoM1) begin
               state_d = StDcmRst;
            end
         end
         StRelMem: begin
            tmo_d = tmo_q + CW'(1);
            if (!lock_s) begin
               state_d = StWaitLock;
            end else if (mem_ready) begin
               state_d = StCoreDly;
            end else if (tmo_q == MemTmoM1) begin
               state_d = StDcmRst;
            end
         end
         StCoreDly: begin
            cnt_d = cnt_q + CW'(1);
            if (!lock_s) begin
               state_d = StWaitLock;
            end else if (cnt_q == StageDlyM1) begin
               state_d = StIoDly;
            end
         end
         StIoDly: begin
            cnt_d = cnt_q + CW'(1);
            if (!lock_s) begin
               state_d = StWaitLock;
            end else if (cnt_q == StageDlyM1) begin
               state_d = StRun;
            end
         end
         StRun: begin
            if (!lock_s) begin
               state_d = StWaitLock;
               if (lost_q != 8'hFF) begin
                  lost_d = lost_q + 8'd1;
               end
            end
         end
         StDcmRst: begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == DcmLenM1) begin
               state_d = StWaitLock;
            end
         end
         StFault: begin
            state_d = StFault;
         end
         default: begin
            state_d = StWaitLock;
         end
      endcase

      // Retries exhausted: go straight to FAULT instead of pulsing the DCM again.
      if ((state_d == StDcmRst) && (state_q != StDcmRst)) begin
         if (retry_q == MaxRetry) begin
            state_d = StFault;
         end else begin
            retry_d = retry_q + RW'(1);
         end
      end
      if ((state_d == StRun) && (state_q != StRun)) begin
         retry_d = '0;
      end
      if (state_d != state_q) begin
         cnt_d = '0;
         tmo_d = '0;
      end
   end

   // Outputs are decoded from the next state so they change on the state-entry edge.
   always_comb begin
      mem_d   = 1'b0;
      core_d  = 1'b0;
      io_d    = 1'b0;
      dcm_d   = 1'b0;
      done_d  = 1'b0;
      fault_d = 1'b0;
      unique case (state_d)
         StRelMem, StCoreDly: begin
            mem_d = 1'b1;
         end
         StIoDly: begin
            mem_d  = 1'b1;
            core_d = 1'b1;
         end
         StRun: begin
            mem_d  = 1'b1;
            core_d = 1'b1;
            io_d   = 1'b1;
            done_d = 1'b1;
         end
         StDcmRst: begin
            dcm_d = 1'b1;
         end
         StFault: begin
            fault_d = 1'b1;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or negedge async_n) begin
      if (!async_n) begin
         state_q    <= StWaitLock;
         cnt_q      <= '0;
         tmo_q      <= '0;
         retry_q    <= '0;
         lost_q     <= '0;
         rst_mem_n  <= 1'b0;
         rst_core_n <= 1'b0;
         rst_io_n   <= 1'b0;
         dcm_rst    <= 1'b0;
         seq_done   <= 1'b0;
         fault      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         tmo_q      <= tmo_d;
         retry_q    <= retry_d;
         lost_q     <= lost_d;
         rst_mem_n  <= mem_d;
         rst_core_n <= core_d;
         rst_io_n   <= io_d;
         dcm_rst    <= dcm_d;
         seq_done   <= done_d;
         fault      <= fault_d;
      end
   end

   assign lost_cnt = lost_q;

endmodule
